// File: rtl/ep_pkg.sv
// ep_pkg: shared widths, history entry type, replay state encoding and strength decay helper.
package ep_pkg;
    localparam int NUM_PAIRS = 6;
    localparam int PAIR_W = 3;
    localparam int STR_W = 4;
    typedef struct packed {
        logic [PAIR_W-1:0] pair;
        logic [STR_W-1:0]  str;
    } entry_t;
    typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_t;
    function automatic logic [STR_W-1:0] decay(input logic [STR_W-1:0] str, input logic [STR_W-1:0] age);
        return (str > age) ? str - age : '0;
    endfunction
endpackage

// File: rtl/episode_replay_if.sv
// episode_replay_if: episode capture, gamma prior and replay handshake signals of episode_replay.
interface episode_replay_if;
    import ep_pkg::*;
    logic gamma_tick, theta_tick, ep_valid, replay_req, replay_ready;
    logic [PAIR_W-1:0] ep_winner, prior_pair, replay_pair;
    logic [STR_W-1:0] ep_strength, prior_bias, replay_strength;
    logic prior_valid, replay_valid, replay_busy, replay_done;
    modport slave (
        input  gamma_tick, theta_tick, ep_winner, ep_strength, ep_valid, replay_req, replay_ready,
        output prior_pair, prior_bias, prior_valid, replay_pair, replay_strength, replay_valid,
               replay_busy, replay_done
    );
    modport master (
        output gamma_tick, theta_tick, ep_winner, ep_strength, ep_valid, replay_req, replay_ready,
        input  prior_pair, prior_bias, prior_valid, replay_pair, replay_strength, replay_valid,
               replay_busy, replay_done
    );
endinterface

// File: rtl/ep_history_ring.sv
// ep_history_ring: DEPTH-entry episode ring with two ordered write ports (a before b), indexed read and count.
module ep_history_ring
    import ep_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_a,
    input  logic          we_b,
    input  entry_t        d_a,
    input  entry_t        d_b,
    input  logic [PW-1:0] rd_idx,
    output entry_t        rd_data,
    output entry_t        newest,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic [PW-1:0] oldest_nxt
);
    entry_t mem [DEPTH];
    logic [PW-1:0] head, head_nxt;
    logic [CW:0] sum;
    // oldest slot as seen after this cycle's writes, so a burst starting now includes them
    always_comb begin
        sum = {1'b0, count} + (CW+1)'(we_a) + (CW+1)'(we_b);
        count_nxt = (sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : sum[CW-1:0];
        head_nxt = head + PW'(we_a) + PW'(we_b);
        oldest_nxt = head_nxt - count_nxt[PW-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            count <= '0;
        end else begin
            head <= head_nxt;
            count <= count_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (we_a) mem[head] <= d_a;
        if (we_b) mem[head + PW'(we_a)] <= d_b;
    end
    assign rd_data = mem[rd_idx];
    assign newest = mem[head - PW'(1)];
endmodule

// File: rtl/episode_replay.sv
// episode_replay: episode history capture with gamma-rate prior output and handshaked replay bursts.
// Define EPISODE_REPLAY_DECAY_EN to decay the prior bias by the gamma age of the newest entry.
module episode_replay
    import ep_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    episode_replay_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    state_t state, state_nxt;
    entry_t cap_d, pend_d, d_a, rd_data, newest;
    logic strobe, cap, pend_v, idle, we_a, we_b, last, prior_valid;
    logic [CW-1:0] count, count_nxt, len;
    logic [PW-1:0] oldest_nxt, start, idx;
    logic [PAIR_W-1:0] prior_pair;
    logic [STR_W-1:0] bias, prior_bias;
    ep_history_ring #(.DEPTH(DEPTH)) u_ring (
        .clk(clk), .rst(rst), .we_a(we_a), .we_b(we_b), .d_a(d_a), .d_b(cap_d),
        .rd_idx(start + idx), .rd_data(rd_data), .newest(newest),
        .count(count), .count_nxt(count_nxt), .oldest_nxt(oldest_nxt)
    );
    assign idle = state == IDLE;
    assign cap = strobe && bus.ep_valid && bus.ep_winner < PAIR_W'(NUM_PAIRS);
    assign cap_d = '{pair: bus.ep_winner, str: bus.ep_strength};
    // a held-back pending entry is older than a capture arriving in the same idle cycle
    assign we_a = idle && (pend_v || cap);
    assign we_b = idle && pend_v && cap;
    assign d_a = pend_v ? pend_d : cap_d;
    assign last = CW'(idx) == len - CW'(1);
`ifdef EPISODE_REPLAY_DECAY_EN
    logic [STR_W-1:0] age;
    always_ff @(posedge clk) begin
        if (rst) age <= '0;
        else if (we_a) age <= '0;
        else if (bus.gamma_tick && age != '1) age <= age + STR_W'(1);
    end
    assign bias = decay(newest.str, age);
`else
    assign bias = newest.str;
`endif
    always_comb begin
        state_nxt = idle ? ((bus.replay_req && count != '0) ? REPLAY : IDLE)
                  : (state == REPLAY) ? ((bus.replay_ready && last) ? DONE : REPLAY) : IDLE;
        bus.replay_busy = state == REPLAY;
        bus.replay_valid = state == REPLAY;
        bus.replay_done = state == DONE;
        bus.replay_pair = (state == REPLAY) ? rd_data.pair : '0;
        bus.replay_strength = (state == REPLAY) ? rd_data.str : '0;
        bus.prior_pair = prior_pair;
        bus.prior_bias = prior_bias;
        bus.prior_valid = prior_valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            strobe <= 1'b0;
            pend_v <= 1'b0;
            pend_d <= '0;
            start <= '0;
            len <= '0;
            idx <= '0;
            prior_pair <= '0;
            prior_bias <= '0;
            prior_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            strobe <= bus.theta_tick;
            if (!idle && cap) begin
                pend_v <= 1'b1;
                pend_d <= cap_d;
            end else if (idle) begin
                pend_v <= 1'b0;
            end
            if (idle && state_nxt == REPLAY) begin
                start <= oldest_nxt;
                len <= count_nxt;
                idx <= '0;
            end else if (state == REPLAY && bus.replay_ready) begin
                idx <= idx + PW'(1);
            end
            if (bus.gamma_tick) begin
                prior_valid <= idle && count != '0;
                if (idle && count != '0) begin
                    prior_pair <= newest.pair;
                    prior_bias <= bias;
                end
            end
        end
    end
endmodule

// File: tb/tb_episode_replay.sv
// tb_episode_replay: table vectors, directed corner sequences and a queue-based random reference model.
module tb_episode_replay;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [2:0] p;
        logic [3:0] s;
    } ent_t;
    typedef struct {
        logic th, v;
        logic [2:0] w;
        logic [3:0] s;
        logic req, rdy, g;
        int rv, rp, rs, dn, pv, pp, pb;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    episode_replay_if bus();
    episode_replay #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    ent_t hist[$];
    ent_t burst[$];
    ent_t pend;
    bit pend_v, in_b, dpulse, th_d;
    int age;
    bit m_pv;
    int m_pp, m_pb;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int rv, input int rp, input int rs, input int dn,
                           input int pv, input int pp, input int pb);
        chk({tag, ".replay_valid"}, int'(bus.replay_valid), rv);
        chk({tag, ".replay_busy"}, int'(bus.replay_busy), rv);
        chk({tag, ".replay_pair"}, int'(bus.replay_pair), rp);
        chk({tag, ".replay_strength"}, int'(bus.replay_strength), rs);
        chk({tag, ".replay_done"}, int'(bus.replay_done), dn);
        chk({tag, ".prior_valid"}, int'(bus.prior_valid), pv);
        chk({tag, ".prior_pair"}, int'(bus.prior_pair), pp);
        chk({tag, ".prior_bias"}, int'(bus.prior_bias), pb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic th, input logic v, input logic [2:0] w, input logic [3:0] s,
                          input logic req, input logic rdy, input logic g);
        bus.theta_tick = th;
        bus.ep_valid = v;
        bus.ep_winner = w;
        bus.ep_strength = s;
        bus.replay_req = req;
        bus.replay_ready = rdy;
        bus.gamma_tick = g;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic capture(input logic [2:0] w, input logic [3:0] s);
        set_in(1, 1, w, s, 0, bus.replay_ready, 0);
        tick();
        bus.theta_tick = 1'b0;
        tick();
        bus.ep_valid = 1'b0;
    endtask

    function automatic int mbias(input ent_t e);
`ifdef EPISODE_REPLAY_DECAY_EN
        return (int'(e.s) > age) ? int'(e.s) - age : 0;
`else
        return int'(e.s);
`endif
    endfunction

    task automatic model_step();
        ent_t w[$];
        ent_t c;
        bit idl, cp, go;
        if (rst) begin
            hist.delete();
            burst.delete();
            pend_v = 0; in_b = 0; dpulse = 0; th_d = 0; age = 0;
            m_pv = 0; m_pp = 0; m_pb = 0;
            return;
        end
        idl = !in_b && !dpulse;
        cp = th_d && bus.ep_valid && bus.ep_winner <= 3'd5;
        c = '{bus.ep_winner, bus.ep_strength};
        go = 0;
        if (idl) begin
            if (pend_v) w.push_back(pend);
            pend_v = 0;
            if (cp) w.push_back(c);
        end else if (cp) begin
            pend_v = 1;
            pend = c;
        end
        if (bus.gamma_tick) begin
            m_pv = idl && hist.size() > 0;
            if (m_pv) begin
                m_pp = int'(hist[$].p);
                m_pb = mbias(hist[$]);
            end
        end
        if (w.size() > 0) age = 0;
        else if (bus.gamma_tick && age < 15) age++;
        if (in_b) begin
            if (bus.replay_ready) begin
                void'(burst.pop_front());
                if (burst.size() == 0) begin
                    in_b = 0;
                    dpulse = 1;
                end
            end
        end else if (dpulse) dpulse = 0;
        else if (bus.replay_req && hist.size() > 0) go = 1;
        foreach (w[i]) begin
            hist.push_back(w[i]);
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
        if (go) begin
            burst = hist;
            in_b = 1;
        end
        th_d = bus.theta_tick;
    endtask

    initial begin
        vec_t tbl[12];
        int exp_bias[7];
        int rp, rs;
        tbl[0]  = '{1, 1, 2, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 2, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 5, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 5, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 1, 2, 6, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 1, 5, 3, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 8};
`ifdef EPISODE_REPLAY_DECAY_EN
        exp_bias = '{5, 4, 3, 2, 1, 0, 0};
`else
        exp_bias = '{5, 5, 5, 5, 5, 5, 5};
`endif
        set_in(0, 0, 0, 0, 0, 1, 0);
        do_reset();
        foreach (tbl[i]) begin
            set_in(tbl[i].th, tbl[i].v, tbl[i].w, tbl[i].s, tbl[i].req, tbl[i].rdy, tbl[i].g);
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].rv, tbl[i].rp, tbl[i].rs, tbl[i].dn,
                    tbl[i].pv, tbl[i].pp, tbl[i].pb);
        end

        do_reset();
        for (int i = 1; i <= 5; i++) capture(3'(i), 4'(i));
        bus.replay_req = 1'b1;
        tick();
        bus.replay_req = 1'b0;
        chk_out("wrap.first", 1, 2, 2, 0, 0, 0, 0);
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk_out($sformatf("wrap.e%0d", k), 1, k, k, 0, 0, 0, 0);
        end
        tick();
        chk_out("wrap.done", 0, 0, 0, 1, 0, 0, 0);
        tick();
        chk_out("wrap.idle", 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        capture(1, 9);
        capture(2, 10);
        capture(3, 11);
        bus.replay_req = 1'b1;
        tick();
        bus.replay_req = 1'b0;
        chk_out("stall.e1", 1, 1, 9, 0, 0, 0, 0);
        tick();
        chk_out("stall.e2", 1, 2, 10, 0, 0, 0, 0);
        bus.replay_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("stall.hold%0d", k), 1, 2, 10, 0, 0, 0, 0);
        end
        bus.replay_ready = 1'b1;
        tick();
        chk_out("stall.e3", 1, 3, 11, 0, 0, 0, 0);
        tick();
        chk_out("stall.done", 0, 0, 0, 1, 0, 0, 0);

        do_reset();
        capture(4, 7);
        capture(0, 2);
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();
        chk_out("pend.e1", 1, 4, 7, 0, 0, 0, 0);
        set_in(1, 1, 3, 5, 0, 0, 0);
        tick();
        chk_out("pend.theta", 1, 4, 7, 0, 0, 0, 0);
        bus.theta_tick = 1'b0;
        tick();
        chk_out("pend.strobe", 1, 4, 7, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 0);
        tick();
        chk_out("pend.e2", 1, 0, 2, 0, 0, 0, 0);
        tick();
        chk_out("pend.done", 0, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        bus.gamma_tick = 1'b1;
        tick();
        bus.gamma_tick = 1'b0;
        chk_out("pend.prior", 0, 0, 0, 0, 1, 3, 5);
        bus.replay_req = 1'b1;
        tick();
        bus.replay_req = 1'b0;
        chk_out("pend.r1", 1, 4, 7, 0, 1, 3, 5);
        tick();
        chk_out("pend.r2", 1, 0, 2, 0, 1, 3, 5);
        tick();
        chk_out("pend.r3", 1, 3, 5, 0, 1, 3, 5);
        tick();
        chk_out("pend.rdone", 0, 0, 0, 1, 1, 3, 5);

        do_reset();
        capture(2, 5);
        bus.gamma_tick = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_out($sformatf("decay%0d", k), 0, 0, 0, 0, 1, 2, exp_bias[k]);
        end
        bus.gamma_tick = 1'b0;

        do_reset();
        capture(6, 9);
        bus.gamma_tick = 1'b1;
        tick();
        bus.gamma_tick = 1'b0;
        chk_out("bad_winner.prior", 0, 0, 0, 0, 0, 0, 0);
        bus.replay_req = 1'b1;
        tick();
        bus.replay_req = 1'b0;
        chk_out("bad_winner.req", 0, 0, 0, 0, 0, 0, 0);
        capture(1, 1);
        capture(2, 2);
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();
        bus.replay_req = 1'b0;
        chk_out("abort.busy", 1, 1, 1, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk_out("abort.rst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        bus.replay_ready = 1'b1;
        tick();
        chk_out("abort.after1", 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_out("abort.after2", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            rst = (i == 0) || ($urandom_range(199) == 0);
            set_in($urandom_range(99) < 30, $urandom_range(99) < 80, 3'($urandom_range(7)),
                   4'($urandom_range(15)), $urandom_range(99) < 20, $urandom_range(99) < 60,
                   $urandom_range(99) < 30);
            tick();
            model_step();
            rp = 0;
            rs = 0;
            if (in_b) begin
                rp = int'(burst[0].p);
                rs = int'(burst[0].s);
            end
            chk_out("rnd", int'(in_b), rp, rs, int'(dpulse), int'(m_pv), m_pp, m_pb);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
